i2c_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `i2c_controller` master among `NUM_REQ` independent requesters. It sits directly upstream of the controller:
- accepts per-requester transaction requests (address, R/W, write data);
- selects one requester and launches it through the controller's enable/ready handshake;
- returns read data plus a one-cycle completion pulse to the winner.

It also guards the launch phase with an acceptance timeout, so a stalled controller cannot hang the requesters.

---
 rtl/i2c_req_arbiter_if.sv | 34 +++
 rtl/i2c_req_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_req_arbiter_if.sv
// rtl/i2c_req_arbiter_if.sv - requester and controller-side signal bundle for i2c_req_arbiter
interface i2c_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_BW = 7,
    parameter int DATA_BW = 8
);
    logic [NUM_REQ-1:0]         i_req;
    logic [NUM_REQ-1:0]         i_req_rw;
    logic [NUM_REQ*ADDR_BW-1:0] i_req_addr;
    logic [NUM_REQ*DATA_BW-1:0] i_req_data;
    logic [NUM_REQ-1:0]         o_gnt;
    logic [NUM_REQ-1:0]         o_done;
    logic                       o_err;
    logic [DATA_BW-1:0]         o_rx_data;
    logic                       o_busy;
    logic                       o_ctrl_enable;
    logic                       o_ctrl_rw;
    logic [ADDR_BW-1:0]         o_ctrl_addr;
    logic [DATA_BW-1:0]         o_ctrl_data;
    logic                       i_ctrl_ready;
    logic [DATA_BW-1:0]         i_ctrl_rx_data;

    modport slave (
        input  i_req, i_req_rw, i_req_addr, i_req_data, i_ctrl_ready, i_ctrl_rx_data,
        output o_gnt, o_done, o_err, o_rx_data, o_busy,
               o_ctrl_enable, o_ctrl_rw, o_ctrl_addr, o_ctrl_data
    );

    modport master (
        output i_req, i_req_rw, i_req_addr, i_req_data, i_ctrl_ready, i_ctrl_rx_data,
        input  o_gnt, o_done, o_err, o_rx_data, o_busy,
               o_ctrl_enable, o_ctrl_rw, o_ctrl_addr, o_ctrl_data
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - shares one i2c_controller among NUM_REQ requesters (round-robin)
// Define I2C_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_BW        = 7,
    parameter int DATA_BW        = 8,
    parameter int ACCEPT_TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    i2c_req_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(ACCEPT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_ABORT  = 2'd2,
        S_BUSY   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]     r_win, w_win_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;
    logic [DATA_BW-1:0]   r_rx_data, w_rx_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_en, w_en_nxt;
    logic                 r_rw, w_rw_nxt;
    logic [ADDR_BW-1:0]   r_addr, w_addr_nxt;
    logic [DATA_BW-1:0]   r_data, w_data_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

    logic [NUM_REQ-1:0]   w_req_eff;
    logic                 w_found;
    logic [PTR_W-1:0]     w_sel;
    logic [PTR_W-1:0]     w_ptr_adv;

    function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ)
            s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // The just-finished requester still holds i_req during its done cycle; mask it out.
    assign w_req_eff = bus.i_req & ~r_done;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
            if (!w_found && w_req_eff[i]) begin
                w_found = 1'b1;
                w_sel   = PTR_W'(i);
            end
`else
            if (!w_found && w_req_eff[wrap_idx(int'(r_ptr), i)]) begin
                w_found = 1'b1;
                w_sel   = wrap_idx(int'(r_ptr), i);
            end
`endif
        end
    end

`ifdef I2C_ARB_FIXED_PRIO_EN
    assign w_ptr_adv = '0;
`else
    assign w_ptr_adv = wrap_idx(int'(r_win), 1);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_rx_nxt    = r_rx_data;
        w_en_nxt    = r_en;
        w_rw_nxt    = r_rw;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found && bus.i_ctrl_ready) begin
                    w_win_nxt   = w_sel;
                    w_gnt_nxt   = NUM_REQ'(1) << w_sel;
                    w_en_nxt    = 1'b1;
                    w_rw_nxt    = bus.i_req_rw[w_sel];
                    w_addr_nxt  = bus.i_req_addr[w_sel*ADDR_BW +: ADDR_BW];
                    w_data_nxt  = bus.i_req_data[w_sel*DATA_BW +: DATA_BW];
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!bus.i_ctrl_ready) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = S_BUSY;
                end else if (r_cnt >= CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = S_ABORT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_ABORT: begin
                // Ready falling here is a late acceptance, not an abort.
                if (!bus.i_ctrl_ready) begin
                    w_state_nxt = S_BUSY;
                end else begin
                    w_done_nxt  = r_gnt;
                    w_err_nxt   = 1'b1;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_adv;
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus.i_ctrl_ready) begin
                    if (r_rw)
                        w_rx_nxt = bus.i_ctrl_rx_data;
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_adv;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rx_data <= '0;
            r_busy    <= 1'b0;
            r_en      <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rx_data <= w_rx_nxt;
            r_busy    <= w_busy_nxt;
            r_en      <= w_en_nxt;
            r_rw      <= w_rw_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.o_gnt         = r_gnt;
    assign bus.o_done        = r_done;
    assign bus.o_err         = r_err;
    assign bus.o_rx_data     = r_rx_data;
    assign bus.o_busy        = r_busy;
    assign bus.o_ctrl_enable = r_en;
    assign bus.o_ctrl_rw     = r_rw;
    assign bus.o_ctrl_addr   = r_addr;
    assign bus.o_ctrl_data   = r_data;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - directed vector bench for i2c_req_arbiter
module tb_i2c_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    i2c_req_arbiter_if #(.NUM_REQ(NR), .ADDR_BW(AW), .DATA_BW(DW)) bus ();

    i2c_req_arbiter #(
        .NUM_REQ(NR), .ADDR_BW(AW), .DATA_BW(DW), .ACCEPT_TIMEOUT(TO)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    typedef struct {
        int            idx;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] slave_rx;
        logic [NR-1:0] exp_gnt;
        logic [DW-1:0] exp_rx;
    } vec_t;

    vec_t vecs[4];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.i_req_rw[k]          = rw;
        bus.i_req_addr[k*AW +: AW] = a;
        bus.i_req_data[k*DW +: DW] = d;
        bus.i_req[k]             = 1'b1;
    endtask

    task automatic wait_gnt(output int idx);
        for (int c = 0; c < 40 && bus.o_gnt == '0; c++)
            tick();
        idx = -1;
        for (int k = 0; k < NR; k++)
            if (bus.o_gnt[k])
                idx = k;
        if (bus.o_gnt == '0)
            check("wait_gnt_bound", 32'd0, 32'd1);
    endtask

    task automatic wait_en_low();
        for (int c = 0; c < TO + 10 && bus.o_ctrl_enable; c++)
            tick();
        if (bus.o_ctrl_enable)
            check("wait_en_low_bound", 32'd1, 32'd0);
    endtask

    // Controller model: accept, stay busy two cycles, then return to ready with rx data.
    task automatic finish_txn(input logic [DW-1:0] rx);
        bus.i_ctrl_ready = 1'b0;
        tick();
        tick();
        tick();
        bus.i_ctrl_rx_data = rx;
        bus.i_ctrl_ready   = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
        $fatal(1);
    end

    initial begin
        int            idx;
        int            cnt;
        int            exp_order[5];
        logic [NR-1:0] seen;

        vecs[0] = '{idx: 1, rw: 1'b0, addr: 7'h50, data: 8'hA5, slave_rx: 8'h11, exp_gnt: 4'b0010, exp_rx: 8'h00};
        vecs[1] = '{idx: 2, rw: 1'b1, addr: 7'h3C, data: 8'h00, slave_rx: 8'h96, exp_gnt: 4'b0100, exp_rx: 8'h96};
        vecs[2] = '{idx: 3, rw: 1'b0, addr: 7'h12, data: 8'h5A, slave_rx: 8'h33, exp_gnt: 4'b1000, exp_rx: 8'h96};
        vecs[3] = '{idx: 0, rw: 1'b1, addr: 7'h7F, data: 8'hFF, slave_rx: 8'hC3, exp_gnt: 4'b0001, exp_rx: 8'hC3};
        exp_order = '{0, 1, 2, 3, 0};

        bus.i_req          = '0;
        bus.i_req_rw       = '0;
        bus.i_req_addr     = '0;
        bus.i_req_data     = '0;
        bus.i_ctrl_ready   = 1'b1;
        bus.i_ctrl_rx_data = '0;
        tick();
        tick();
        check("rst_gnt",  32'(bus.o_gnt), 32'h0);
        check("rst_done", 32'(bus.o_done), 32'h0);
        check("rst_err",  32'(bus.o_err), 32'h0);
        check("rst_rx",   32'(bus.o_rx_data), 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_en",   32'(bus.o_ctrl_enable), 32'h0);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            set_req(vecs[i].idx, vecs[i].rw, vecs[i].addr, vecs[i].data);
            tick();
            check("vec_gnt",  32'(bus.o_gnt), 32'(vecs[i].exp_gnt));
            check("vec_en",   32'(bus.o_ctrl_enable), 32'h1);
            check("vec_busy", 32'(bus.o_busy), 32'h1);
            check("vec_rw",   32'(bus.o_ctrl_rw), 32'(vecs[i].rw));
            check("vec_addr", 32'(bus.o_ctrl_addr), 32'(vecs[i].addr));
            check("vec_data", 32'(bus.o_ctrl_data), 32'(vecs[i].data));
            finish_txn(vecs[i].slave_rx);
            check("vec_done",     32'(bus.o_done), 32'(vecs[i].exp_gnt));
            check("vec_err",      32'(bus.o_err), 32'h0);
            check("vec_gnt_clr",  32'(bus.o_gnt), 32'h0);
            check("vec_rx",       32'(bus.o_rx_data), 32'(vecs[i].exp_rx));
            bus.i_req = '0;
            tick();
            check("vec_done_1cyc", 32'(bus.o_done), 32'h0);
            check("vec_rx_hold",   32'(bus.o_rx_data), 32'(vecs[i].exp_rx));
        end

        // Reset in the middle of a BUSY transaction.
        set_req(2, 1'b0, 7'h21, 8'h44);
        tick();
        bus.i_ctrl_ready = 1'b0;
        tick();
        tick();
        rstn             = 1'b0;
        bus.i_req        = '0;
        bus.i_ctrl_ready = 1'b1;
        tick();
        check("mrst_gnt",  32'(bus.o_gnt), 32'h0);
        check("mrst_done", 32'(bus.o_done), 32'h0);
        check("mrst_err",  32'(bus.o_err), 32'h0);
        check("mrst_rx",   32'(bus.o_rx_data), 32'h0);
        check("mrst_busy", 32'(bus.o_busy), 32'h0);
        check("mrst_en",   32'(bus.o_ctrl_enable), 32'h0);
        check("mrst_rw",   32'(bus.o_ctrl_rw), 32'h0);
        check("mrst_addr", 32'(bus.o_ctrl_addr), 32'h0);
        check("mrst_data", 32'(bus.o_ctrl_data), 32'h0);
        tick();
        rstn = 1'b1;
        seen = '0;
        for (int c = 0; c < 5; c++) begin
            seen |= bus.o_done;
            tick();
        end
        check("mrst_no_done", 32'(seen), 32'h0);
        set_req(0, 1'b0, 7'h01, 8'h01);
        set_req(2, 1'b0, 7'h02, 8'h02);
        tick();
        check("mrst_first_gnt", 32'(bus.o_gnt), 32'h1);
        finish_txn(8'h00);
        check("mrst_first_done", 32'(bus.o_done), 32'h1);
        bus.i_req[0] = 1'b0;
        tick();
        check("b2b_gnt", 32'(bus.o_gnt), 32'h4);
        finish_txn(8'h00);
        check("b2b_done", 32'(bus.o_done), 32'h4);
        bus.i_req = '0;
        tick();

        // Round-robin with all requesters, requester 0 returning after done[1].
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        for (int k = 0; k < NR; k++)
            set_req(k, 1'b0, 7'(8'h40 + k), 8'(k));
        for (int n = 0; n < 5; n++) begin
            wait_gnt(idx);
            check("rr_order", 32'(idx), 32'(exp_order[n]));
            finish_txn(8'h00);
            if (idx >= 0)
                bus.i_req[idx] = 1'b0;
            if (n == 1)
                bus.i_req[0] = 1'b1;
        end
        bus.i_req = '0;
        tick();

        // Launch timeout: controller never accepts.
        set_req(0, 1'b0, 7'h55, 8'h66);
        wait_gnt(idx);
        cnt = 0;
        for (int c = 0; c < TO + 10 && bus.o_ctrl_enable; c++) begin
            cnt++;
            tick();
        end
        check("to_en_cycles", 32'(cnt), 32'(TO));
        check("to_no_done_yet", 32'(bus.o_done), 32'h0);
        tick();
        check("to_done", 32'(bus.o_done), 32'h1);
        check("to_err",  32'(bus.o_err), 32'h1);
        check("to_gnt",  32'(bus.o_gnt), 32'h0);
        check("to_busy", 32'(bus.o_busy), 32'h0);
        bus.i_req = '0;
        tick();
        check("to_err_1cyc", 32'(bus.o_err), 32'h0);

        // Late acceptance: ready falls during the ABORT cycle.
        set_req(1, 1'b1, 7'h22, 8'h00);
        wait_gnt(idx);
        check("late_gnt", 32'(bus.o_gnt), 32'h2);
        wait_en_low();
        bus.i_ctrl_ready = 1'b0;
        tick();
        check("late_no_done", 32'(bus.o_done), 32'h0);
        check("late_busy",    32'(bus.o_busy), 32'h1);
        tick();
        bus.i_ctrl_rx_data = 8'h5E;
        bus.i_ctrl_ready   = 1'b1;
        tick();
        check("late_done", 32'(bus.o_done), 32'h2);
        check("late_err",  32'(bus.o_err), 32'h0);
        check("late_rx",   32'(bus.o_rx_data), 32'h5E);
        bus.i_req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
